// File: rtl/lfsr_stream_ctrl.sv
// -----------------------------------------------------------------------------
// lfsr_stream_ctrl
//   Stream-cipher sequencer built around a 26-stage Fibonacci LFSR with taps at
//   stages 26, 8, 7 and 1. A non-zero seed is loaded and then WARMUP_CYCLES
//   steps are discarded. After that, each accepted plaintext byte is XORed with
//   8 freshly generated keystream bits. Bytes are handled one at a time:
//   accept, generate, deliver, then the block is ready for the next byte.
//
//   Stage numbering follows the usual 1..26 shift-register picture. Stage 1
//   takes the feedback and stage 26 is the output tap. Both the seed port and
//   the internal register list the stages from MSB to LSB:
//     bit 25 (MSB) = stage 1, ..., bit 0 (LSB) = stage 26.
//   A seed of 26'h0000001 therefore puts a single 1 in the output stage.
//
// Ports
//   clk, rst_n        clock; synchronous active-low reset
//   seed_valid, seed  one-cycle seed load strobe, accepted in any state
//   seed_err          one-cycle pulse after an all-zero seed is rejected
//   busy              high while in warm-up, generating, or holding output
//   s_valid/s_ready/s_data   plaintext byte input (valid/ready)
//   m_valid/m_ready/m_data   ciphertext byte output (valid/ready)
//   byte_cnt          bytes delivered since the last seed load (wraps)
// -----------------------------------------------------------------------------
module lfsr_stream_ctrl #(
  parameter int WARMUP_CYCLES = 64,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_valid,
  input  logic [25:0]      seed,
  output logic             seed_err,
  output logic             busy,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic [CNT_W-1:0] byte_cnt
);

  localparam int WCNT_W = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WARMUP = 3'd1,
    RUN    = 3'd2,
    GEN    = 3'd3,
    OUT    = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [25:0]       q;      // bit 25 = stage 1 ... bit 0 = stage 26
  logic [WCNT_W-1:0] wcnt;   // warm-up steps still to discard
  logic [2:0]        bcnt;   // keystream bits generated for the current byte
  logic [6:0]        ks;     // keystream bits collected so far, MSB first
  logic [7:0]        s_lat;  // plaintext byte being encrypted

  logic seed_zero;
  logic step;
  logic fb;
  logic ks_bit;

  assign seed_zero = (seed == '0);

  // Feedback from stages 26, 8, 7 and 1. The output bit is stage 26 before
  // the shift.
  assign fb     = q[0] ^ q[18] ^ q[19] ^ q[25];
  assign ks_bit = q[0];

  // The register advances only while warming up or generating. A seed strobe
  // in the same cycle takes over: a good seed reloads q, and a zero seed
  // freezes it.
  assign step = ((state == WARMUP) || (state == GEN)) && !seed_valid;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: reset is synchronous, so it appears only inside the clocked branch
  // and the sensitivity list holds the clock alone.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_nxt gets its default before any branch. This keeps every path
  // assigned, so synthesis builds plain muxes and does not infer a latch.
  always_comb begin
    state_nxt = state;
    if (seed_valid) begin
      if (seed_zero)               state_nxt = IDLE;
      else if (WARMUP_CYCLES == 0) state_nxt = RUN;
      else                         state_nxt = WARMUP;
    end else begin
      case (state)
        WARMUP:  if (wcnt == WCNT_W'(1)) state_nxt = RUN;
        RUN:     if (s_valid)            state_nxt = GEN;
        GEN:     if (bcnt == 3'd7)       state_nxt = OUT;
        OUT:     if (m_ready)            state_nxt = RUN;
        default: state_nxt = state;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: Moore outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    s_ready = (state == RUN);
    busy    = (state == WARMUP) || (state == GEN) || (state == OUT);
  end

  // ---------------------------------------------------------------------------
  // Datapath: LFSR, counters, byte capture and output register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked assignment is non-blocking. Each register then sees the
  // values from before the edge, no matter what order the statements are in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q        <= '0;
      wcnt     <= '0;
      bcnt     <= '0;
      ks       <= '0;
      s_lat    <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      seed_err <= 1'b0;
      byte_cnt <= '0;
    end else begin
      seed_err <= seed_valid && seed_zero;

      if (seed_valid) begin
        // Any byte in progress or waiting at the output is abandoned.
        m_valid <= 1'b0;
        bcnt    <= '0;
        if (!seed_zero) begin
          q        <= seed;
          wcnt     <= WCNT_W'(WARMUP_CYCLES);
          byte_cnt <= '0;
        end
      end else begin
        if (step) q <= {fb, q[25:1]};

        case (state)
          WARMUP: wcnt <= wcnt - WCNT_W'(1);
          RUN: begin
            if (s_valid) begin
              s_lat <= s_data;
              bcnt  <= '0;
            end
          end
          GEN: begin
            ks   <= {ks[5:0], ks_bit};
            bcnt <= bcnt + 3'd1;
            if (bcnt == 3'd7) begin
              m_data  <= s_lat ^ {ks, ks_bit};
              m_valid <= 1'b1;
            end
          end
          OUT: begin
            if (m_ready) begin
              m_valid  <= 1'b0;
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lfsr_stream_ctrl
//   Directed bench for lfsr_stream_ctrl. It drives two instances:
//     z : WARMUP_CYCLES = 0
//     w : WARMUP_CYCLES = 64
//   The data, seed and handshake inputs are shared. Each instance has its own
//   seed strobe, so an instance that never gets a seed stays idle and ignores
//   the shared stream. The sel signal picks which instance the helper tasks
//   observe.
//   Expected ciphertext comes from hand-computed constants. It also comes from
//   a stage-by-stage LFSR model kept in its own 1..26 array.
// -----------------------------------------------------------------------------
module tb_lfsr_stream_ctrl;

  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic [25:0] seed;
  logic s_valid, m_ready;
  logic [7:0] s_data;
  logic z_seed_valid, w_seed_valid;

  logic z_seed_err, z_busy, z_s_ready, z_m_valid;
  logic [7:0] z_m_data;
  logic [CNT_W-1:0] z_byte_cnt;
  logic w_seed_err, w_busy, w_s_ready, w_m_valid;
  logic [7:0] w_m_data;
  logic [CNT_W-1:0] w_byte_cnt;

  logic sel;  // 0 = observe z, 1 = observe w
  logic sel_seed_err, sel_busy, sel_s_ready, sel_m_valid;
  logic [7:0] sel_m_data;
  logic [CNT_W-1:0] sel_byte_cnt;

  assign sel_seed_err = sel ? w_seed_err : z_seed_err;
  assign sel_busy     = sel ? w_busy     : z_busy;
  assign sel_s_ready  = sel ? w_s_ready  : z_s_ready;
  assign sel_m_valid  = sel ? w_m_valid  : z_m_valid;
  assign sel_m_data   = sel ? w_m_data   : z_m_data;
  assign sel_byte_cnt = sel ? w_byte_cnt : z_byte_cnt;

  always #5 clk = ~clk;

  lfsr_stream_ctrl #(.WARMUP_CYCLES(0), .CNT_W(CNT_W)) u_z (
    .clk(clk), .rst_n(rst_n), .seed_valid(z_seed_valid), .seed(seed),
    .seed_err(z_seed_err), .busy(z_busy), .s_valid(s_valid), .s_ready(z_s_ready),
    .s_data(s_data), .m_valid(z_m_valid), .m_ready(m_ready), .m_data(z_m_data),
    .byte_cnt(z_byte_cnt)
  );

  lfsr_stream_ctrl #(.WARMUP_CYCLES(64), .CNT_W(CNT_W)) u_w (
    .clk(clk), .rst_n(rst_n), .seed_valid(w_seed_valid), .seed(seed),
    .seed_err(w_seed_err), .busy(w_busy), .s_valid(s_valid), .s_ready(w_s_ready),
    .s_data(s_data), .m_valid(w_m_valid), .m_ready(m_ready), .m_data(w_m_data),
    .byte_cnt(w_byte_cnt)
  );

  int passed = 0;
  int total  = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Each call moves one cycle forward. It returns at the falling edge, where
  // outputs are sampled and inputs are changed.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- reference LFSR model (stages 1..26) ----------------
  logic st [1:26];

  task automatic model_load(input logic [25:0] s);
    for (int k = 1; k <= 26; k++) st[k] = s[26-k];
  endtask

  task automatic model_step(output logic ob);
    logic f;
    ob = st[26];
    f  = st[26] ^ st[8] ^ st[7] ^ st[1];
    for (int k = 26; k >= 2; k--) st[k] = st[k-1];
    st[1] = f;
  endtask

  task automatic model_skip(input int n);
    logic b;
    for (int i = 0; i < n; i++) model_step(b);
  endtask

  task automatic model_byte(output logic [7:0] kb);
    logic b;
    kb = '0;
    for (int i = 0; i < 8; i++) begin
      model_step(b);
      kb = {kb[6:0], b};
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic load_seed(input logic [25:0] s);
    seed = s;
    if (sel) w_seed_valid = 1'b1;
    else     z_seed_valid = 1'b1;
    tick();
    z_seed_valid = 1'b0;
    w_seed_valid = 1'b0;
  endtask

  // Counts cycles that busy stays high. It also counts any m_valid seen in
  // that time.
  task automatic wait_busy(output int n, output int mv);
    n  = 0;
    mv = 0;
    while (sel_busy && n < 200) begin
      if (sel_m_valid) mv++;
      tick();
      n++;
    end
  endtask

  // Sends one byte and collects the result. lat is the number of clock edges
  // from the accept edge to the delivering handshake edge. The lat value is
  // only meaningful when stall == 0.
  task automatic xfer(input logic [7:0] d, input int stall,
                      output logic [7:0] got, output int lat);
    int n;
    int bad;
    s_data  = d;
    s_valid = 1'b1;
    n = 0;
    while (!sel_s_ready && n < 50) begin
      tick();
      n++;
    end
    check("s_ready_wait", 32'(sel_s_ready), 32'd1);
    tick();                       // accept edge
    s_valid = 1'b0;
    m_ready = (stall == 0);
    lat = 0;
    while (!sel_m_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("m_valid_seen", 32'(sel_m_valid), 32'd1);
    got = sel_m_data;
    if (stall > 0) begin
      bad = 0;
      for (int i = 0; i < stall; i++) begin
        tick();
        if (sel_m_data !== got || sel_m_valid !== 1'b1 || sel_s_ready !== 1'b0)
          bad++;
      end
      check("stall_hold", 32'(bad), 32'd0);
      m_ready = 1'b1;
    end
    tick();                       // handshake edge
    lat++;
    m_ready = 1'b0;
    check("m_valid_drop", 32'(sel_m_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got, kb, c1, c2, r1, r2;
    int lat, n, mv;
    logic [25:0] s1, s2;
    s1 = 26'h2A5F0C3;
    s2 = 26'h1B3C7E5;

    rst_n = 1'b0; seed = '0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    z_seed_valid = 1'b0; w_seed_valid = 1'b0; sel = 1'b0;
    @(negedge clk);

    // 1: reset held for 3 cycles
    repeat (3) tick();
    check("rst_z_s_ready",  32'(z_s_ready),  32'd0);
    check("rst_z_m_valid",  32'(z_m_valid),  32'd0);
    check("rst_z_busy",     32'(z_busy),     32'd0);
    check("rst_z_byte_cnt", 32'(z_byte_cnt), 32'd0);
    check("rst_w_s_ready",  32'(w_s_ready),  32'd0);
    check("rst_w_busy",     32'(w_busy),     32'd0);
    check("rst_w_m_data",   32'(w_m_data),   32'd0);
    check("rst_w_seed_err", 32'(w_seed_err), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_s_ready", 32'(z_s_ready), 32'd0);

    // 2: zero warm-up, seed = 1, single 1 in the output stage
    sel = 1'b0;
    load_seed(26'h0000001);
    model_load(26'h0000001);
    check("z_busy_after_seed",    32'(sel_busy),    32'd0);
    check("z_s_ready_after_seed", 32'(sel_s_ready), 32'd1);
    xfer(8'h00, 0, got, lat);
    check("z_byte0_data", 32'(got), 32'h80);
    check("z_byte0_lat",  32'(lat), 32'd9);
    model_byte(kb);
    check("z_byte0_model", 32'(got), 32'(8'h00 ^ kb));
    xfer(8'h00, 0, got, lat);
    check("z_byte1_data", 32'(got), 32'h00);
    check("z_byte_cnt2",  32'(sel_byte_cnt), 32'd2);

    // 3: all-zero seed rejected
    load_seed(26'h0);
    check("zero_seed_err",     32'(sel_seed_err), 32'd1);
    check("zero_seed_s_ready", 32'(sel_s_ready),  32'd0);
    check("zero_seed_busy",    32'(sel_busy),     32'd0);
    tick();
    check("zero_seed_err_pulse", 32'(sel_seed_err), 32'd0);
    repeat (3) tick();
    check("zero_seed_stay_idle", 32'(sel_s_ready),  32'd0);

    // reset during GEN drops the in-flight byte
    load_seed(26'h0000001);
    s_data = 8'h55; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    repeat (2) tick();
    check("gen_busy", 32'(sel_busy), 32'd1);
    rst_n = 1'b0;
    tick();
    check("midrst_busy",    32'(sel_busy),    32'd0);
    check("midrst_s_ready", 32'(sel_s_ready), 32'd0);
    check("midrst_m_valid", 32'(sel_m_valid), 32'd0);
    rst_n = 1'b1;
    mv = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (sel_m_valid) mv++;
    end
    check("midrst_no_output", 32'(mv), 32'd0);

    // 4: 64-cycle warm-up
    sel = 1'b1;
    load_seed(s1);
    model_load(s1);
    model_skip(64);
    wait_busy(n, mv);
    check("warmup_len",     32'(n),           32'd64);
    check("warmup_s_ready", 32'(sel_s_ready), 32'd1);
    xfer(8'h3C, 0, got, lat);
    model_byte(kb);
    check("w_byte0_data", 32'(got), 32'(8'h3C ^ kb));
    check("w_byte0_lat",  32'(lat), 32'd9);
    check("w_byte_cnt1",  32'(sel_byte_cnt), 32'd1);

    // 5: stall in OUT for 20 cycles, so the keystream continues without gaps
    xfer(8'hA7, 20, got, lat);
    model_byte(kb);
    check("stall_data",     32'(got), 32'(8'hA7 ^ kb));
    check("stall_byte_cnt", 32'(sel_byte_cnt), 32'd2);
    xfer(8'h00, 0, got, lat);
    model_byte(kb);
    check("post_stall_data", 32'(got), 32'(kb));
    check("w_byte_cnt3",     32'(sel_byte_cnt), 32'd3);

    // 6: reseed during GEN
    s_data = 8'h5A; s_valid = 1'b1;
    tick();                       // accepted
    s_valid = 1'b0;
    repeat (3) tick();
    load_seed(s2);
    check("reseed_byte_cnt", 32'(sel_byte_cnt), 32'd0);
    wait_busy(n, mv);
    check("reseed_warmup",    32'(n),  32'd64);
    check("reseed_no_output", 32'(mv), 32'd0);
    model_load(s2);
    model_skip(64);
    xfer(8'h11, 0, c1, lat);
    model_byte(kb);
    check("reseed_byte0", 32'(c1), 32'(8'h11 ^ kb));
    xfer(8'hEE, 0, c2, lat);
    model_byte(kb);
    check("reseed_byte1", 32'(c2), 32'(8'hEE ^ kb));
    check("reseed_byte_cnt2", 32'(sel_byte_cnt), 32'd2);

    load_seed(s2);
    wait_busy(n, mv);
    xfer(8'h11, 0, r1, lat);
    xfer(8'hEE, 0, r2, lat);
    check("repeat_seed_byte0", 32'(r1), 32'(c1));
    check("repeat_seed_byte1", 32'(r2), 32'(c2));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
